// File: rtl/wb_mbox_pkg.sv
// Shared constants and helpers for the Wishbone mailbox FIFO block.
package wb_mbox_pkg;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  // Occupancy needs one bit beyond the pointer so that "full" (== depth) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_mbox_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty decode from the level register.
module wb_mbox_sync_fifo
  import wb_mbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DATA_W = 32,
  localparam int LVL_W = lvl_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; contents are only observable through a valid level.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wb_mbox_fifo.sv
// Wishbone classic slave exposing a one-word mailbox: writes feed TX FIFO, reads drain RX FIFO.
// Optional WB_MBOX_ERR_EN: overflow/underflow accesses terminate with err instead of ack.
module wb_mbox_fifo
  import wb_mbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = 32,
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [AW-1:0]    wb_adr_i,
  input  logic [WB_SW-1:0] wb_sel_i,
  input  logic [WB_DW-1:0] wb_dat_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  output logic             wb_stall_o,
  output logic [WB_DW-1:0] wb_dat_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [WB_DW-1:0] tx_data_o,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  input  logic [WB_DW-1:0] rx_data_i,
  output logic [LVL_W-1:0] tx_level_o,
  output logic [LVL_W-1:0] rx_level_o,
  output logic             ovf_o,
  output logic             unf_o,
  input  logic             flag_clr_i
);

  function automatic logic [WB_DW-1:0] sel_mask(input logic [WB_DW-1:0] d,
                                                input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] r;
    for (int i = 0; i < WB_SW; i++) r[i*8 +: 8] = sel[i] ? d[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  logic             accept, tx_push, rx_pop, ovf_set, unf_set;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [WB_DW-1:0] tx_head, rx_head;
  logic             busy, term_p1, fault_p1;
  logic [WB_DW-1:0] dat_p1;
  logic             unused_adr;

  assign unused_adr = ^wb_adr_i;

  assign accept  = wb_cyc_i & wb_stb_i & ~busy;
  assign tx_push = accept & wb_we_i & ~tx_full;
  assign ovf_set = accept & wb_we_i & tx_full;
  assign rx_pop  = accept & ~wb_we_i & ~rx_empty;
  assign unf_set = accept & ~wb_we_i & rx_empty;

  wb_mbox_sync_fifo #(.DEPTH(DEPTH), .DATA_W(WB_DW)) u_tx (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (tx_push),
    .pop     (tx_ready_i),
    .wr_data (sel_mask(wb_dat_i, wb_sel_i)),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level_o)
  );

  wb_mbox_sync_fifo #(.DEPTH(DEPTH), .DATA_W(WB_DW)) u_rx (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (rx_valid_i),
    .pop     (rx_pop),
    .wr_data (rx_data_i),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level_o)
  );

  // ---- stage p1: termination, read data and sticky flags ----
  // busy persists while the master keeps stb up after termination, so a held
  // strobe is one transfer; it drops once stb is seen low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy     <= 1'b0;
      term_p1  <= 1'b0;
      fault_p1 <= 1'b0;
      dat_p1   <= '0;
      ovf_o    <= 1'b0;
      unf_o    <= 1'b0;
    end else begin
      busy     <= accept | (busy & wb_cyc_i & wb_stb_i);
      term_p1  <= accept;
      fault_p1 <= ovf_set | unf_set;
      if (accept & ~wb_we_i) dat_p1 <= rx_empty ? '0 : rx_head;
      ovf_o    <= ovf_set | (ovf_o & ~flag_clr_i);
      unf_o    <= unf_set | (unf_o & ~flag_clr_i);
    end
  end

`ifdef WB_MBOX_ERR_EN
  assign wb_ack_o = term_p1 & ~fault_p1;
  assign wb_err_o = term_p1 & fault_p1;
`else
  logic unused_fault;
  assign unused_fault = fault_p1;
  assign wb_ack_o     = term_p1;
  assign wb_err_o     = 1'b0;
`endif

  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wb_dat_o   = dat_p1;
  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_empty ? '0 : tx_head;
  assign rx_ready_o = ~rx_full;

endmodule
